// File: rtl/display_scan_mux_if.sv
// -----------------------------------------------------------------------------
// display_scan_mux_if
//
// Purpose:
//   Groups the signals between the datapath and the multiplexed display driver.
//   The datapath side loads new digit values. The display side drives the
//   board pins and reports status.
//
// Parameters:
//   N_DIG      number of hex digits carried on the bus (1..8)
//
// Signals:
//   load       single-cycle strobe from the datapath; captures data_in/dp_in
//   data_in    4*N_DIG hex nibbles, digit k = data_in[4k+3:4k]
//   dp_in      N_DIG decimal-point bits, 1 = lit
//   seg        shared segment bus {dp,g,f,e,d,c,b,a} at pin polarity
//   an         per-digit enables at pin polarity
//   frame_tick one-cycle pulse marking the first displayed slot of a new frame
//   pending    shadow register holds a value that has not been committed yet
//
// Modports:
//   master     datapath side (drives load/data_in/dp_in)
//   slave      display_scan_mux side (drives seg/an/frame_tick/pending)
// -----------------------------------------------------------------------------
interface display_scan_mux_if #(
  parameter int N_DIG = 4
);

  logic                 load;
  logic [4*N_DIG-1:0]   data_in;
  logic [N_DIG-1:0]     dp_in;
  logic [7:0]           seg;
  logic [N_DIG-1:0]     an;
  logic                 frame_tick;
  logic                 pending;

  modport master (
    output load,
    output data_in,
    output dp_in,
    input  seg,
    input  an,
    input  frame_tick,
    input  pending
  );

  modport slave (
    input  load,
    input  data_in,
    input  dp_in,
    output seg,
    output an,
    output frame_tick,
    output pending
  );

endinterface

// File: rtl/display_scan_mux.sv
// -----------------------------------------------------------------------------
// display_scan_mux
//
// Purpose:
//   Drives N_DIG time-multiplexed hex digits from one shared 8-bit segment bus.
//   A prescaler sets how long each digit slot lasts. A digit index walks the
//   digits. New values land in a shadow register and move to the displayed
//   (active) register only when the scan wraps from the last digit to digit 0.
//   This means a frame never mixes old and new digits.
//
// Parameters:
//   N_DIG           number of digits, 1..8
//   DIV             clock cycles per digit slot, >= 1
//   SEG_ACTIVE_LOW  1 = seg/an are active-low (common anode), 0 = active-high
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   bus (slave)     load/data_in/dp_in in; seg/an/frame_tick/pending out
//
// Optional feature (macro DISPLAY_SCAN_MUX_LZ_BLANK_EN):
//   When defined, leading zeros are blanked. A zero digit above the most
//   significant nonzero digit has segments g..a forced off. Its dp and
//   enable behave normally. Digit 0 is never blanked.
//   When undefined, every digit is always shown.
// -----------------------------------------------------------------------------
module display_scan_mux #(
  parameter int N_DIG          = 4,
  parameter int DIV            = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  display_scan_mux_if.slave bus
);

  // Counter widths stay at least 1 bit so DIV=1 / N_DIG=1 still elaborate.
  localparam int PW = (DIV   > 1) ? $clog2(DIV)   : 1;
  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  localparam logic [PW-1:0]    PRESC_MAX = PW'(DIV - 1);
  localparam logic [IW-1:0]    IDX_MAX   = IW'(N_DIG - 1);

  // XOR masks that convert active-high internal patterns to pin polarity.
  // They are also the "all off" reset values.
  localparam logic [7:0]       SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [N_DIG-1:0] AN_OFF    = SEG_ACTIVE_LOW ? {N_DIG{1'b1}} : {N_DIG{1'b0}};

  // Scan state
  logic [PW-1:0]      presc_q, presc_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic               tick;
  logic               wrap;

  // Double-buffered digit data
  logic [4*N_DIG-1:0] shadowData_q, shadowData_d;
  logic [N_DIG-1:0]   shadowDp_q, shadowDp_d;
  logic [4*N_DIG-1:0] activeData_q, activeData_d;
  logic [N_DIG-1:0]   activeDp_q, activeDp_d;
  logic               pending_q, pending_d;

  // Registered pin outputs and frame marker pipeline
  logic [7:0]         seg_q, seg_d;
  logic [N_DIG-1:0]   an_q, an_d;
  logic               wrapSeen_q;
  logic               frameTick_q;

  // Current-digit selection
  logic [3:0]         curNib;
  logic               curDp;
  logic               curBlank;
  logic [N_DIG-1:0]   anRaw;
  logic [7:0]         segRaw;
  logic [N_DIG-1:0]   blankMask;

  // Active-high g..a pattern for one hex nibble.
  function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  // Prescaler and digit index next state. A tick ends the current slot.
  // A wrap is a tick on the last digit, so the next slot is digit 0 of a
  // new frame. With N_DIG=1 every tick is a wrap.
  always_comb begin
    tick    = (presc_q == PRESC_MAX);
    wrap    = tick && (idx_q == IDX_MAX);
    presc_d = tick ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end
  end

  // Double-buffer control. A load always lands in the shadow register, and
  // the last load wins. At a wrap, a load in the same cycle goes straight to
  // the active register. Otherwise a pending shadow value is committed. In
  // both cases nothing is left pending.
  always_comb begin
    shadowData_d = shadowData_q;
    shadowDp_d   = shadowDp_q;
    activeData_d = activeData_q;
    activeDp_d   = activeDp_q;
    pending_d    = pending_q;

    if (bus.load) begin
      shadowData_d = bus.data_in;
      shadowDp_d   = bus.dp_in;
    end

    if (wrap) begin
      if (bus.load) begin
        activeData_d = bus.data_in;
        activeDp_d   = bus.dp_in;
        pending_d    = 1'b0;
      end else if (pending_q) begin
        activeData_d = shadowData_q;
        activeDp_d   = shadowDp_q;
        pending_d    = 1'b0;
      end
    end else if (bus.load) begin
      pending_d = 1'b1;
    end
  end

`ifdef DISPLAY_SCAN_MUX_LZ_BLANK_EN
  logic seenNonZero;

  // Leading-zero mask. Scan from the top digit down. A digit is blanked while
  // no nonzero nibble has been seen at or above it. Digit 0 is left out of the
  // scan, so an all-zero value still shows one "0".
  always_comb begin
    blankMask   = '0;
    seenNonZero = 1'b0;
    for (int k = N_DIG - 1; k >= 1; k--) begin
      if (activeData_q[4*k +: 4] != 4'h0) begin
        seenNonZero = 1'b1;
      end
      blankMask[k] = ~seenNonZero;
    end
  end
`else
  // Without the feature every digit is always displayed.
  assign blankMask = '0;
`endif

  // Select the digit addressed by idx. The mux is written as a loop compare
  // so that an idx beyond N_DIG-1 (not reachable) can never index out of
  // range. The matching enable bit is built one-hot in the same pass.
  always_comb begin
    curNib   = 4'h0;
    curDp    = 1'b0;
    curBlank = 1'b0;
    anRaw    = '0;
    for (int k = 0; k < N_DIG; k++) begin
      if (idx_q == IW'(k)) begin
        curNib   = activeData_q[4*k +: 4];
        curDp    = activeDp_q[k];
        curBlank = blankMask[k];
        anRaw[k] = 1'b1;
      end
    end
    segRaw = {curDp, curBlank ? 7'h00 : hexToSeg(curNib)};
    seg_d  = segRaw ^ SEG_OFF;
    an_d   = anRaw ^ AN_OFF;
  end

  // Scan counters and data registers. Reset clears everything immediately,
  // so a reset in the middle of a frame cannot leave a partial commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      shadowData_q <= '0;
      shadowDp_q   <= '0;
      activeData_q <= '0;
      activeDp_q   <= '0;
      pending_q    <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadowData_q <= shadowData_d;
      shadowDp_q   <= shadowDp_d;
      activeData_q <= activeData_d;
      activeDp_q   <= activeDp_d;
      pending_q    <= pending_d;
    end
  end

  // Pin registers. seg/an follow idx with one cycle of latency. frame_tick
  // is delayed twice from the wrap so that it lines up with the first cycle
  // in which seg/an show digit 0 of the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q       <= SEG_OFF;
      an_q        <= AN_OFF;
      wrapSeen_q  <= 1'b0;
      frameTick_q <= 1'b0;
    end else begin
      seg_q       <= seg_d;
      an_q        <= an_d;
      wrapSeen_q  <= wrap;
      frameTick_q <= wrapSeen_q;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = frameTick_q;
  assign bus.pending    = pending_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_display_scan_mux
//
// Directed bench for display_scan_mux with N_DIG=4, DIV=4 and active-low pins.
// Each digit slot lasts 4 cycles, so a frame lasts 16 cycles. "cyc" counts
// rising edges since the last reset release. After edge n (n >= 1), the pins
// show digit ((n-1)/4)%4. Wraps happen on edges 16, 32, 48, ...
// Expected values are hand-computed from the hex pattern table.
// -----------------------------------------------------------------------------
module tb_display_scan_mux;

  localparam int N_DIG = 4;
  localparam int DIV   = 4;

`ifdef DISPLAY_SCAN_MUX_LZ_BLANK_EN
  // A leading zero digit is fully dark.
  localparam logic [7:0] LEAD_ZERO = 8'hFF;
`else
  // A leading zero digit shows "0" (~0x3F).
  localparam logic [7:0] LEAD_ZERO = 8'hC0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  display_scan_mux_if #(.N_DIG(N_DIG)) dutIf ();

  display_scan_mux #(
    .N_DIG         (N_DIG),
    .DIV           (DIV),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (dutIf)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Drive the datapath side of the interface.
  task automatic applyStimulus(input logic ld, input logic [15:0] data, input logic [3:0] dp);
    dutIf.load    = ld;
    dutIf.data_in = data;
    dutIf.dp_in   = dp;
  endtask

  // One comparison: count it, and count and report it if it fails.
  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%02h expected=%02h", tag, observed, expected);
    end
  endtask

  // Compare both the enables and the segment bus.
  task automatic checkDigit(input string tag, input logic [3:0] expAn, input logic [7:0] expSeg);
    checkOutput({tag, "_an"}, {4'h0, dutIf.an}, {4'h0, expAn});
    checkOutput({tag, "_seg"}, dutIf.seg, expSeg);
  endtask

  // Advance n rising edges, then settle 2 ns past the edge.
  task automatic advance(input int n);
    repeat (n) @(posedge clk);
    cyc += n;
    #2;
  endtask

  task automatic advanceTo(input int target);
    if (target > cyc) advance(target - cyc);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 16'h0000, 4'h0);
    repeat (3) @(posedge clk);
    #2;

    // Reset state
    checkDigit("rst", 4'hF, 8'hFF);
    checkOutput("rst_pending", {7'h0, dutIf.pending}, 8'h00);
    checkOutput("rst_ftick", {7'h0, dutIf.frame_tick}, 8'h00);

    // Release reset. The first cycle after release is still all off.
    rst_n = 1'b1;
    cyc   = 0;
    checkDigit("rel0", 4'hF, 8'hFF);

    // Walk of an all-zero value
    advanceTo(1);
    checkDigit("walk_d0", 4'b1110, 8'hC0);
    advanceTo(4);
    checkDigit("walk_d0_end", 4'b1110, 8'hC0);
    for (int d = 1; d < 4; d++) begin
      advanceTo(1 + 4 * d);
      checkDigit($sformatf("walk_d%0d", d), ~(4'b0001 << d), LEAD_ZERO);
    end

    // frame_tick is high only on the first digit-0 cycle of a new frame
    advanceTo(16);
    checkOutput("ftick_c16", {7'h0, dutIf.frame_tick}, 8'h00);
    advanceTo(17);
    checkOutput("ftick_c17", {7'h0, dutIf.frame_tick}, 8'h01);
    checkDigit("frame2_d0", 4'b1110, 8'hC0);
    advanceTo(18);
    checkOutput("ftick_c18", {7'h0, dutIf.frame_tick}, 8'h00);

    // Mid-frame load of 12AF with dp on digit 2
    applyStimulus(1'b1, 16'h12AF, 4'b0100);
    advance(1);
    applyStimulus(1'b0, 16'h0000, 4'h0);
    checkOutput("load1_pending", {7'h0, dutIf.pending}, 8'h01);
    advanceTo(29);
    checkDigit("load1_hold_d3", 4'b0111, LEAD_ZERO);
    checkOutput("load1_pending_hold", {7'h0, dutIf.pending}, 8'h01);
    advanceTo(32);
    checkOutput("load1_commit_pending", {7'h0, dutIf.pending}, 8'h00);
    checkDigit("load1_wrap_old", 4'b0111, LEAD_ZERO);
    advanceTo(33);
    checkDigit("load1_d0", 4'b1110, 8'h8E);
    checkOutput("load1_ftick", {7'h0, dutIf.frame_tick}, 8'h01);

    // Two loads in one frame; only the second may appear
    advanceTo(34);
    applyStimulus(1'b1, 16'h1111, 4'h0);
    advance(1);
    applyStimulus(1'b0, 16'h0000, 4'h0);
    checkOutput("dbl_pending", {7'h0, dutIf.pending}, 8'h01);
    advanceTo(37);
    checkDigit("load1_d1", 4'b1101, 8'h88);
    advanceTo(38);
    applyStimulus(1'b1, 16'h2222, 4'h0);
    advance(1);
    applyStimulus(1'b0, 16'h0000, 4'h0);
    advanceTo(41);
    checkDigit("load1_d2", 4'b1011, 8'h24);
    advanceTo(45);
    checkDigit("load1_d3", 4'b0111, 8'hF9);
    for (int d = 0; d < 4; d++) begin
      advanceTo(49 + 4 * d);
      checkDigit($sformatf("dbl_d%0d", d), ~(4'b0001 << d), 8'hA4);
    end
    checkOutput("dbl_pending_clr", {7'h0, dutIf.pending}, 8'h00);

    // Load on the wrap cycle (edge 64) goes straight to the active register
    advanceTo(63);
    applyStimulus(1'b1, 16'h5A3C, 4'b0001);
    advance(1);
    applyStimulus(1'b0, 16'h0000, 4'h0);
    checkOutput("wrapld_pending", {7'h0, dutIf.pending}, 8'h00);
    advanceTo(65);
    checkDigit("wrapld_d0", 4'b1110, 8'h46);
    checkOutput("wrapld_ftick", {7'h0, dutIf.frame_tick}, 8'h01);
    advanceTo(69);
    checkDigit("wrapld_d1", 4'b1101, 8'hB0);
    advanceTo(73);
    checkDigit("wrapld_d2", 4'b1011, 8'h88);
    advanceTo(77);
    checkDigit("wrapld_d3", 4'b0111, 8'h92);

    // Asynchronous reset mid-slot while a value is pending
    advanceTo(78);
    applyStimulus(1'b1, 16'h7777, 4'b1111);
    advance(1);
    applyStimulus(1'b0, 16'h0000, 4'h0);
    checkOutput("arst_pre_pending", {7'h0, dutIf.pending}, 8'h01);
    advanceTo(81);
    rst_n = 1'b0;
    #1;
    checkDigit("arst", 4'hF, 8'hFF);
    checkOutput("arst_pending", {7'h0, dutIf.pending}, 8'h00);
    checkOutput("arst_ftick", {7'h0, dutIf.frame_tick}, 8'h00);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc   = 0;
    checkDigit("arst_rel0", 4'hF, 8'hFF);
    advanceTo(1);
    checkDigit("arst_d0", 4'b1110, 8'hC0);
    advanceTo(13);
    checkDigit("arst_d3", 4'b0111, LEAD_ZERO);

    // Value 0050: two leading zeros above a 5
    advanceTo(14);
    applyStimulus(1'b1, 16'h0050, 4'h0);
    advance(1);
    applyStimulus(1'b0, 16'h0000, 4'h0);
    advanceTo(17);
    checkDigit("lz_d0", 4'b1110, 8'hC0);
    advanceTo(21);
    checkDigit("lz_d1", 4'b1101, 8'h92);
    advanceTo(25);
    checkDigit("lz_d2", 4'b1011, LEAD_ZERO);
    advanceTo(29);
    checkDigit("lz_d3", 4'b0111, LEAD_ZERO);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
